// File: rtl/pulse_cond_pkg.sv
// Shared types and helpers for the multi-channel pulse conditioner.
package pulse_cond_pkg;

   // Shared edge selection, encoded as the edge_mode input pins.
   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_NONE = 2'b11
   } edge_mode_t;

   // Per-channel hold/auto-repeat state.
   typedef enum logic [1:0] {
      LOW         = 2'd0,
      HOLD_WAIT   = 2'd1,
      HOLD_REPEAT = 2'd2
   } hold_state_t;

   // True when a level transition of the given direction should produce a pulse.
   function automatic logic edge_fires(edge_mode_t mode, logic rise, logic fall);
      return (rise && (mode == EDGE_RISE || mode == EDGE_BOTH)) ||
             (fall && (mode == EDGE_FALL || mode == EDGE_BOTH));
   endfunction

   // Auto-repeat is only meaningful when rising edges are being reported.
   function automatic logic repeat_allowed(edge_mode_t mode);
      return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
   endfunction

endpackage

// File: rtl/pulse_cond_channel.sv
// One channel: synchroniser, debouncer, edge detector and auto-repeat FSM.
module pulse_cond_channel
   import pulse_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       i_signal,
   input  logic [1:0] i_edge_mode,
   input  logic       i_repeat_en,
   output logic       o_level,
   output logic       o_pulse
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_level;
   logic                   r_level_d;
   logic [DB_W-1:0]        r_db_cnt;
   hold_state_t            r_state;
   hold_state_t            w_state_nxt;
   logic [RPT_W-1:0]       r_rpt_cnt;
   logic [RPT_W-1:0]       w_rpt_cnt_nxt;
   logic                   r_pulse;
   logic                   w_pulse_nxt;
   logic                   w_sync;
   logic                   w_rise;
   logic                   w_fall;
   logic                   w_rpt_ok;
   edge_mode_t             w_mode;

   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_rise   = r_level & ~r_level_d;
   assign w_fall   = ~r_level & r_level_d;
   assign w_mode   = edge_mode_t'(i_edge_mode);
   assign w_rpt_ok = i_repeat_en & repeat_allowed(w_mode);

   assign o_level  = r_level;
   assign o_pulse  = r_pulse;

   // Plain shift-register synchroniser, no logic between stages.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_signal};
      end
   end

   // Debounce: accept the synced value after DEBOUNCE_CYCLES consecutive mismatches.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_level  <= 1'b0;
         r_db_cnt <= '0;
      end else if (w_sync != r_level) begin
         if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_level  <= w_sync;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
         end
      end else begin
         r_db_cnt <= '0;
      end
   end

   // Delayed copy of the debounced level for edge detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_level_d <= 1'b0;
      end else begin
         r_level_d <= r_level;
      end
   end

   // Hold FSM state, repeat counter and registered pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= LOW;
         r_rpt_cnt <= '0;
         r_pulse   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rpt_cnt <= w_rpt_cnt_nxt;
         r_pulse   <= w_pulse_nxt;
      end
   end

   // Next state and pulse; a falling level overrides any repeat terminal count.
   always_comb begin
      w_state_nxt   = r_state;
      w_rpt_cnt_nxt = r_rpt_cnt;
      w_pulse_nxt   = 1'b0;
      if (w_fall) begin
         w_state_nxt   = LOW;
         w_rpt_cnt_nxt = '0;
         w_pulse_nxt   = edge_fires(w_mode, 1'b0, 1'b1);
      end else begin
         case (r_state)
            LOW: begin
               w_rpt_cnt_nxt = '0;
               if (w_rise) begin
                  w_state_nxt = HOLD_WAIT;
                  w_pulse_nxt = edge_fires(w_mode, 1'b1, 1'b0);
               end
            end
            HOLD_WAIT: begin
               if (!w_rpt_ok) begin
                  w_rpt_cnt_nxt = '0;
               end else if (r_rpt_cnt == RPT_W'(REPEAT_DELAY - 1)) begin
                  w_state_nxt   = HOLD_REPEAT;
                  w_rpt_cnt_nxt = '0;
                  w_pulse_nxt   = 1'b1;
               end else begin
                  w_rpt_cnt_nxt = r_rpt_cnt + RPT_W'(1);
               end
            end
            HOLD_REPEAT: begin
               if (!w_rpt_ok) begin
                  w_state_nxt   = HOLD_WAIT;
                  w_rpt_cnt_nxt = '0;
               end else if (r_rpt_cnt == RPT_W'(REPEAT_PERIOD - 1)) begin
                  w_rpt_cnt_nxt = '0;
                  w_pulse_nxt   = 1'b1;
               end else begin
                  w_rpt_cnt_nxt = r_rpt_cnt + RPT_W'(1);
               end
            end
            default: begin
               w_state_nxt   = LOW;
               w_rpt_cnt_nxt = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/multi_channel_pulse_conditioner.sv
// Array of independent pulse conditioner channels sharing mode controls.
module multi_channel_pulse_conditioner
   import pulse_cond_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] signal_in,
   input  logic [1:0]          edge_mode,
   input  logic                repeat_en,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] pulse
);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      pulse_cond_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
         .clock      (clock),
         .reset_n    (reset_n),
         .i_signal   (signal_in[g]),
         .i_edge_mode(edge_mode),
         .i_repeat_en(repeat_en),
         .o_level    (level_out[g]),
         .o_pulse    (pulse[g])
      );
   end

endmodule

// File: tb/tb_multi_channel_pulse_conditioner.sv
// Directed and randomized bench for multi_channel_pulse_conditioner.
module tb_multi_channel_pulse_conditioner;
   import pulse_cond_pkg::*;

   localparam int NCH  = 4;
   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int RDLY = 8;
   localparam int RPER = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NCH-1:0] sig;
   logic [1:0]     mode;
   logic           rep_en;
   logic [NCH-1:0] lvl_o;
   logic [NCH-1:0] pul_o;

   int checks = 0;
   int errors = 0;

   // Reference model: input history plus timestamp-based repeat schedule.
   logic [NCH-1:0] in_hist[$];
   int             edge_no;
   logic [NCH-1:0] m_lvl, m_prev, m_held, m_pulse;
   int             m_run[NCH];
   int             m_dl[NCH];

   always #5 clk = ~clk;

   multi_channel_pulse_conditioner #(
      .CHANNELS       (NCH),
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY   (RDLY),
      .REPEAT_PERIOD  (RPER)
   ) dut (
      .clock    (clk),
      .reset_n  (rst_n),
      .signal_in(sig),
      .edge_mode(mode),
      .repeat_en(rep_en),
      .level_out(lvl_o),
      .pulse    (pul_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      in_hist.delete();
      edge_no = 0;
      m_lvl   = '0;
      m_prev  = '0;
      m_held  = '0;
      m_pulse = '0;
      for (int c = 0; c < NCH; c++) begin
         m_run[c] = 0;
         m_dl[c]  = -1;
      end
   endtask

   task automatic model_step();
      logic [NCH-1:0] synced, new_lvl;
      logic rose, fell, rep_ok;
      synced  = (edge_no >= SYNC) ? in_hist[edge_no-SYNC] : '0;
      rep_ok  = rep_en && (mode == EDGE_RISE || mode == EDGE_BOTH);
      new_lvl = m_lvl;
      for (int c = 0; c < NCH; c++) begin
         rose = m_lvl[c] && !m_prev[c];
         fell = !m_lvl[c] && m_prev[c];
         m_pulse[c] = 1'b0;
         if (fell) begin
            m_pulse[c] = (mode == EDGE_FALL || mode == EDGE_BOTH);
            m_held[c]  = 1'b0;
            m_dl[c]    = -1;
         end else if (rose) begin
            m_pulse[c] = (mode == EDGE_RISE || mode == EDGE_BOTH);
            m_held[c]  = 1'b1;
            m_dl[c]    = -1;
         end else if (m_held[c]) begin
            if (!rep_ok) begin
               m_dl[c] = -1;
            end else begin
               if (m_dl[c] < 0) m_dl[c] = edge_no + RDLY - 1;
               if (edge_no == m_dl[c]) begin
                  m_pulse[c] = 1'b1;
                  m_dl[c]    = edge_no + RPER;
               end
            end
         end
         if (synced[c] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == DEB) begin
               new_lvl[c] = synced[c];
               m_run[c]   = 0;
            end
         end else begin
            m_run[c] = 0;
         end
      end
      m_prev = m_lvl;
      m_lvl  = new_lvl;
      in_hist.push_back(sig);
      edge_no++;
   endtask

   // One clock: model advances at the edge, outputs compared at the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("model_level", 32'(lvl_o), 32'(m_lvl));
      chk("model_pulse", 32'(pul_o), 32'(m_pulse));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int npl, nlv;
      rst_n  = 1'b0;
      sig    = '0;
      mode   = EDGE_RISE;
      rep_en = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_level", 32'(lvl_o), 32'd0);
      chk("reset_pulse", 32'(pul_o), 32'd0);

      // 1: single rising edge on ch0
      rst_n  = 1'b1;
      sig[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cycle();
         chk("t1_level0", 32'(lvl_o[0]), 32'(k >= 5));
         chk("t1_pulse0", 32'(pul_o[0]), 32'(k == 6));
      end
      sig[0] = 1'b0;
      repeat (12) cycle();

      // 2: short glitch on ch1 is rejected
      mode   = EDGE_BOTH;
      sig[1] = 1'b1;
      npl = 0; nlv = 0;
      for (int k = 0; k < 15; k++) begin
         if (k == 3) sig[1] = 1'b0;
         cycle();
         npl += int'(pul_o[1]);
         nlv += int'(lvl_o[1]);
      end
      chk("t2_pulses", 32'(npl), 32'd0);
      chk("t2_levels", 32'(nlv), 32'd0);

      // 3: falling-only mode on ch2
      mode   = EDGE_FALL;
      sig[2] = 1'b1;
      npl = 0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         npl += int'(pul_o[2]);
      end
      chk("t3_rise_pulses", 32'(npl), 32'd0);
      chk("t3_level_high", 32'(lvl_o[2]), 32'd1);
      sig[2] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         chk("t3_fall_pulse", 32'(pul_o[2]), 32'(k == 6));
      end
      repeat (4) cycle();

      // 4: auto-repeat on ch0
      mode   = EDGE_RISE;
      rep_en = 1'b1;
      sig[0] = 1'b1;
      npl = 0;
      for (int k = 0; k < 45; k++) begin
         if (k == 30) sig[0] = 1'b0;
         cycle();
         npl += int'(pul_o[0]);
         chk("t4_repeat", 32'(pul_o[0]),
             32'((k == 6) || (k >= 14 && k <= 35 && (k - 14) % 3 == 0)));
      end
      chk("t4_pulse_count", 32'(npl), 32'd9);
      rep_en = 1'b0;
      repeat (4) cycle();

      // 5: asynchronous reset while ch3 is held high
      sig[3] = 1'b1;
      for (int k = 0; k < 7; k++) cycle();
      chk("t5_pulse_before_reset", 32'(pul_o[3]), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_level", 32'(lvl_o), 32'd0);
      chk("t5_async_pulse", 32'(pul_o), 32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      npl = 0;
      for (int k = 0; k < 12; k++) begin
         cycle();
         npl += int'(pul_o[3]);
         chk("t5_level3", 32'(lvl_o[3]), 32'(k >= 5));
      end
      chk("t5_pulse_count", 32'(npl), 32'd1);
      sig = '0;
      repeat (12) cycle();

      // 6: all channels together, both and none modes
      mode = EDGE_BOTH;
      sig  = '1;
      for (int k = 0; k < 10; k++) begin
         cycle();
         chk("t6_rise_all", 32'(pul_o), (k == 6) ? 32'hF : 32'h0);
      end
      sig = '0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         chk("t6_fall_all", 32'(pul_o), (k == 6) ? 32'hF : 32'h0);
      end
      mode = EDGE_NONE;
      sig  = '1;
      for (int k = 0; k < 10; k++) begin
         cycle();
         chk("t6_none_pulse", 32'(pul_o), 32'h0);
         chk("t6_none_level", 32'(lvl_o), (k >= 5) ? 32'hF : 32'h0);
      end
      sig = '0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         chk("t6_none_pulse_f", 32'(pul_o), 32'h0);
         chk("t6_none_level_f", 32'(lvl_o), (k >= 5) ? 32'h0 : 32'hF);
      end

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(7) == 0) mode = 2'($urandom_range(3));
         if ($urandom_range(15) == 0) rep_en = ~rep_en;
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(7) == 0) sig[c] = ~sig[c];
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
